// File: rtl/mdu_param.sv
// Multiply/divide unit with HI/LO registers and fixed-latency multi-cycle
// MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, flush (cancel) and sync reset.
module mdu_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [1:0]        op_q, op_d;       // bit1: divide, bit0: unsigned
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  hi_d, lo_d;
  logic              done_d;

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   div_s_b, quot_s, rem_s;
  logic        [WIDTH-1:0]   div_u_b, quot_u, rem_u;
  logic                      div_zero, div_ovf;
  logic        [WIDTH-1:0]   res_hi, res_lo;

  // Result datapath on latched operands; divisor forced to 1 for /0 and
  // MIN/-1 so the divider never sees an undefined case (MIN/1 gives the
  // required MIN quotient with zero remainder).
  always_comb begin
    prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero = (b_q == '0);
    div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    div_s_b  = (div_zero || div_ovf) ? $signed(WIDTH'(1)) : $signed(b_q);
    quot_s   = $signed(a_q) / div_s_b;
    rem_s    = $signed(a_q) % div_s_b;
    div_u_b  = div_zero ? WIDTH'(1) : b_q;
    quot_u   = a_q / div_u_b;
    rem_u    = a_q % div_u_b;
    case (op_q)
      2'd0:    begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      2'd1:    begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      2'd2:    begin res_hi = rem_s;                   res_lo = quot_s;            end
      default: begin res_hi = rem_u;                   res_lo = quot_u;            end
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = CW'(MUL_CYCLES);
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = CW'(DIV_CYCLES);
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!(op_q[1] && div_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi    <= hi_d;
      lo    <= lo_d;
      done  <= done_d;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param: scoreboard of expected HI/LO per issued op.
module tb_mdu_param;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic         busy1, done1;
  logic [W-1:0] hi1, lo1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mhi, mlo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mdu_param #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mdu_param #(.WIDTH(W), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a multi-cycle op, check busy/hold every cycle, then score the commit
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int n,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int   cyc;
    exp_t e;
    sb.push_back({eh, el});
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 0;
    while (done !== 1'b1 && cyc < n + 4) begin
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      chk({tag, "_hold_hi"}, 64'(hi), 64'(mhi));
      chk({tag, "_hold_lo"}, 64'(lo), 64'(mlo));
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(n));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(1));
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
    mhi = eh; mlo = el;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(0));
    chk("rst_hi1", 64'(hi1), 64'(0));
    mhi = '0; mlo = '0;

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 3'd3, 32'd7,         32'd0,        10, mhi,           mlo);
    run_op("divovf",3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,        32'h8000_0000);
    run_op("div0",  3'd2, 32'd7,         32'd0,        10, mhi,           mlo);
    run_op("divu",  3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'h1,         32'h7FFF_FFFC);

    // MTHI then MTLO back to back
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_busy", 64'(busy), 64'(0));
    chk("mthi_done", 64'(done), 64'(0));
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    op = 3'd5; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_busy", 64'(busy), 64'(0));
    chk("mtlo_done", 64'(done), 64'(0));
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_hi", 64'(hi), 64'h1234_5678);
    mhi = 32'h1234_5678; mlo = 32'h9ABC_DEF0;

    // Reserved op is a no-op
    start = 1'b1; op = 3'd6; a = 32'hAAAA_5555; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    chk("rsv_busy", 64'(busy), 64'(0));
    chk("rsv_hi", 64'(hi), 64'(mhi));
    chk("rsv_lo", 64'(lo), 64'(mlo));
    @(negedge clk);
    chk("rsv_done", 64'(done), 64'(0));

    // Cancel on a same-cycle MTHI suppresses it
    start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hDEAD_0001;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cxmt_hi", 64'(hi), 64'(mhi));

    // Cancel three cycles after issue
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("cx1_busy_run", 64'(busy), 64'(1));
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cx1_busy", 64'(busy), 64'(0));
    chk("cx1_hi", 64'(hi), 64'(mhi));
    chk("cx1_lo", 64'(lo), 64'(mlo));
    for (int i = 0; i < 6; i++) begin
      chk("cx1_no_done", 64'(done), 64'(0));
      @(negedge clk);
    end

    // Cancel on the commit edge wins
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("cx2_busy_pre", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cx2_busy", 64'(busy), 64'(0));
    chk("cx2_hi", 64'(hi), 64'(mhi));
    chk("cx2_lo", 64'(lo), 64'(mlo));
    for (int i = 0; i < 4; i++) begin
      chk("cx2_no_done", 64'(done), 64'(0));
      @(negedge clk);
    end

    // Single-cycle latency instance; main instance flushed afterwards
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("n1_busy", 64'(busy1), 64'(1));
    chk("n1_done_early", 64'(done1), 64'(0));
    @(negedge clk);
    chk("n1_busy_end", 64'(busy1), 64'(0));
    chk("n1_done", 64'(done1), 64'(1));
    chk("n1_hi", 64'(hi1), 64'(0));
    chk("n1_lo", 64'(lo1), 64'(12));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("n1_done_pulse", 64'(done1), 64'(0));
    chk("n1_main_busy", 64'(busy), 64'(0));
    chk("n1_main_hi", 64'(hi), 64'(mhi));

    // Reset during a DIV; start held through reset is ignored
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rr_busy", 64'(busy), 64'(0));
    chk("rr_done", 64'(done), 64'(0));
    chk("rr_hi", 64'(hi), 64'(0));
    chk("rr_lo", 64'(lo), 64'(0));
    mhi = '0; mlo = '0;
    for (int i = 0; i < 10; i++) begin
      chk("rr_no_done", 64'(done), 64'(0));
      chk("rr_hold_hi", 64'(hi), 64'(0));
      @(negedge clk);
    end

    run_op("post", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
